aq_vidu_vid_wbt_wb_ctrl: RTL



---
 rtl/aq_vidu_vid_wbt_wb_ctrl_pkg.sv | 25 ++
 rtl/aq_vidu_vid_wb_fifo.sv | 74 +++++++
 rtl/aq_vidu_vid_wbt_wb_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/aq_vidu_vid_wbt_wb_ctrl_pkg.sv
// Shared constants, report payload and vreg decoder for the vector write-back collector.
package aq_vidu_vid_wbt_wb_ctrl_pkg;

   localparam int unsigned VREG_NUM       = 32;
   localparam int unsigned VREG_IDX_W     = 5;
   localparam int unsigned VWB_FIFO_DEPTH = 2;
   localparam int unsigned VWB_CNT_W      = 2;
   localparam int unsigned COLLIDE_CNT_W  = 16;

   typedef logic [VREG_IDX_W-1:0] vreg_idx_t;

   typedef struct packed {
      logic      vld;
      vreg_idx_t vreg;
   } vwb_rpt_t;

   // One-hot decode of a report; all zeros when the report is not valid.
   function automatic logic [VREG_NUM-1:0] vreg_dec(input vwb_rpt_t rpt);
      logic [VREG_NUM-1:0] dec;
      dec           = '0;
      dec[rpt.vreg] = rpt.vld;
      return dec;
   endfunction

endpackage

// File: rtl/aq_vidu_vid_wb_fifo.sv
// Two-entry collision buffer for vector write-back reports: dual push (A then B), single pop.
module aq_vidu_vid_wb_fifo
   import aq_vidu_vid_wbt_wb_ctrl_pkg::*;
(
   input  logic                 wb_clk,
   input  logic                 cpurst_b,
   input  logic                 i_flush,
   input  logic                 i_push_a,
   input  vreg_idx_t            i_push_a_vreg,
   input  logic                 i_push_b,
   input  vreg_idx_t            i_push_b_vreg,
   input  logic                 i_pop,
   output vreg_idx_t            o_head,
   output logic                 o_head_vld,
   output logic [VWB_CNT_W-1:0] o_count
);

   localparam logic [VWB_CNT_W-1:0] CNT_FULL = VWB_CNT_W'(VWB_FIFO_DEPTH);

   logic [VWB_FIFO_DEPTH-1:0][VREG_IDX_W-1:0] r_mem;
   logic [VWB_CNT_W-1:0]                      r_cnt;
   logic [VWB_FIFO_DEPTH-1:0][VREG_IDX_W-1:0] w_mem_nxt;
   logic [VWB_CNT_W-1:0]                      w_cnt_nxt;
   logic                                      w_ovf;

   // Shift out the popped head first, then append pushes in A-then-B order.
   always_comb begin
      w_mem_nxt = r_mem;
      w_cnt_nxt = r_cnt;
      w_ovf     = 1'b0;
      if (i_pop && (r_cnt != '0)) begin
         w_mem_nxt[0] = r_mem[1];
         w_cnt_nxt    = r_cnt - VWB_CNT_W'(1);
      end
      if (i_push_a) begin
         if (w_cnt_nxt < CNT_FULL) begin
            w_mem_nxt[w_cnt_nxt[0]] = i_push_a_vreg;
            w_cnt_nxt               = w_cnt_nxt + VWB_CNT_W'(1);
         end else begin
            w_ovf = 1'b1;
         end
      end
      if (i_push_b) begin
         if (w_cnt_nxt < CNT_FULL) begin
            w_mem_nxt[w_cnt_nxt[0]] = i_push_b_vreg;
            w_cnt_nxt               = w_cnt_nxt + VWB_CNT_W'(1);
         end else begin
            w_ovf = 1'b1;
         end
      end
      if (i_flush) begin
         w_cnt_nxt = '0;
         w_ovf     = 1'b0;
      end
   end

   always_ff @(posedge wb_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_mem <= '0;
         r_cnt <= '0;
      end else begin
         r_mem <= w_mem_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // The issue logic never offers more pushes than the free slots left after the pop.
   a_no_ovf: assert property (@(posedge wb_clk) disable iff (!cpurst_b) !w_ovf);

   assign o_head     = r_mem[0];
   assign o_head_vld = (r_cnt != '0);
   assign o_count    = r_cnt;

endmodule

// File: rtl/aq_vidu_vid_wbt_wb_ctrl.sv
// Vector write-back collector: merges FPU/LSU reports into a one-hot wb_en, queueing collisions.
// Optional collision counter enabled by defining AQ_VIDU_WB_PERF_EN.
module aq_vidu_vid_wbt_wb_ctrl
   import aq_vidu_vid_wbt_wb_ctrl_pkg::*;
(
   input  logic                     cpurst_b,
   input  logic                     wb_clk,
   input  logic                     rtu_vidu_flush_wbt,
   input  logic                     rtu_yy_xx_async_flush,
   input  logic                     vfpu_vidu_wb_vld,
   input  logic [VREG_IDX_W-1:0]    vfpu_vidu_wb_vreg,
   input  logic                     vlsu_vidu_wb_vld,
   input  logic [VREG_IDX_W-1:0]    vlsu_vidu_wb_vreg,
   output logic                     vidu_vfpu_wb_stall,
   output logic                     vidu_vlsu_wb_stall,
   output logic [VREG_NUM-1:0]      vidu_wbt_wb_en,
   output logic                     vidu_wbt_wb_pending,
   output logic [COLLIDE_CNT_W-1:0] vidu_wbt_collide_cnt
);

   localparam logic [VWB_CNT_W-1:0] CNT_FULL = VWB_CNT_W'(VWB_FIFO_DEPTH);

   logic                r_wb_en_unused;
   logic [VREG_NUM-1:0] r_wb_en;
   logic [VREG_NUM-1:0] w_wb_en_nxt;
   logic                w_flush;
   logic                w_stall;
   vreg_idx_t           w_head;
   logic                w_head_vld;
   logic [VWB_CNT_W-1:0] w_count;
   vwb_rpt_t            w_rpt_h;
   vwb_rpt_t            w_rpt_a;
   vwb_rpt_t            w_rpt_b;
   logic                w_a_vld;
   logic                w_b_vld;
   logic                w_a_iss;
   logic                w_b_iss;
   logic                w_push_a;
   logic                w_push_b;

   assign w_flush = rtu_vidu_flush_wbt | rtu_yy_xx_async_flush;
   assign w_stall = (w_count == CNT_FULL);

   assign w_a_vld = vfpu_vidu_wb_vld & ~w_stall;
   assign w_b_vld = vlsu_vidu_wb_vld & ~w_stall;

   // Head always issues; A yields to H; B yields to any issued candidate with the same vreg.
   assign w_a_iss = w_a_vld & (~w_head_vld | (vfpu_vidu_wb_vreg != w_head));
   assign w_b_iss = w_b_vld
                  & ~(w_head_vld & (vlsu_vidu_wb_vreg == w_head))
                  & ~(w_a_iss & (vlsu_vidu_wb_vreg == vfpu_vidu_wb_vreg));

   assign w_push_a = ~w_flush & w_a_vld & ~w_a_iss;
   assign w_push_b = ~w_flush & w_b_vld & ~w_b_iss;

   assign w_rpt_h = '{vld: w_head_vld, vreg: w_head};
   assign w_rpt_a = '{vld: w_a_iss,    vreg: vfpu_vidu_wb_vreg};
   assign w_rpt_b = '{vld: w_b_iss,    vreg: vlsu_vidu_wb_vreg};

   always_comb begin
      w_wb_en_nxt = '0;
      if (!w_flush) begin
         w_wb_en_nxt = vreg_dec(w_rpt_h) | vreg_dec(w_rpt_a) | vreg_dec(w_rpt_b);
      end
   end

   aq_vidu_vid_wb_fifo u_wb_fifo (
      .wb_clk        (wb_clk),
      .cpurst_b      (cpurst_b),
      .i_flush       (w_flush),
      .i_push_a      (w_push_a),
      .i_push_a_vreg (vfpu_vidu_wb_vreg),
      .i_push_b      (w_push_b),
      .i_push_b_vreg (vlsu_vidu_wb_vreg),
      .i_pop         (w_head_vld),
      .o_head        (w_head),
      .o_head_vld    (w_head_vld),
      .o_count       (w_count)
   );

   always_ff @(posedge wb_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_wb_en <= '0;
      end else begin
         r_wb_en <= w_wb_en_nxt;
      end
   end

   assign r_wb_en_unused = 1'b0;

`ifdef AQ_VIDU_WB_PERF_EN
   logic [COLLIDE_CNT_W-1:0] r_collide_cnt;

   // Saturating count of cycles that queued at least one report; flush leaves it intact.
   always_ff @(posedge wb_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_collide_cnt <= '0;
      end else if ((w_push_a | w_push_b) && (r_collide_cnt != '1)) begin
         r_collide_cnt <= r_collide_cnt + COLLIDE_CNT_W'(1);
      end
   end

   assign vidu_wbt_collide_cnt = r_collide_cnt;
`else
   assign vidu_wbt_collide_cnt = '0;
`endif

   assign vidu_vfpu_wb_stall  = w_stall;
   assign vidu_vlsu_wb_stall  = w_stall;
   assign vidu_wbt_wb_en      = r_wb_en | {VREG_NUM{r_wb_en_unused}};
   assign vidu_wbt_wb_pending = w_head_vld;

endmodule
